// File: rtl/layer_sequencer.sv
// layer_sequencer: walks NUM_LAYERS layer headers for one pixel.
// For each layer it fetches eight 16-bit header words from RAM and presents
// the assembled 128-bit header to the ALU for one cycle. It then services the
// ALU's flash and RAM fetch demands, flash first, before moving to the next layer.
//
// Handshake rules: a request (memReq, flashReq, ramReq) rises and then stays
// high with stable address/qualifiers until the matching ack is seen on a rising
// edge. The ack completes the transfer in that same cycle. An ack that arrives
// while its request is low is ignored. No timeout is applied.
module layer_sequencer #(
  parameter int          NUM_LAYERS = 8,
  parameter logic [25:0] HDR_BASE   = 26'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         memReq,
  output logic [25:0]  memAddr,
  input  logic         memAck,
  input  logic [15:0]  memData,
  output logic [127:0] headerOut,
  output logic         headerValid,
  input  logic         readFlashEn,
  input  logic         readRamEn,
  output logic         flashReq,
  output logic         ramReq,
  input  logic         flashAck,
  input  logic         ramAck,
  output logic [3:0]   layerIdx,
  output logic         busy,
  output logic         done,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EVAL  = 3'd2,
    S_FLASH = 3'd3,
    S_RAM   = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);

  state_t         state_q, state_d;
  logic [3:0]     layer_q, layer_d;
  logic [2:0]     wc_q, wc_d;
  logic [127:0]   hdr_q, hdr_d;
  logic           flash_dem_q, flash_dem_d;
  logic           ram_dem_q, ram_dem_d;

  // State and datapath registers; reset abandons any walk in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= 4'd0;
      wc_q        <= 3'd0;
      hdr_q       <= 128'd0;
      flash_dem_q <= 1'b0;
      ram_dem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      wc_q        <= wc_d;
      hdr_q       <= hdr_d;
      flash_dem_q <= flash_dem_d;
      ram_dem_q   <= ram_dem_d;
    end
  end

  // Next-state logic: header shift on each mem ack, demand capture in EVAL.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    wc_d        = wc_q;
    hdr_d       = hdr_q;
    flash_dem_d = flash_dem_q;
    ram_dem_d   = ram_dem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          layer_d = 4'd0;
          wc_d    = 3'd0;
        end
      end
      S_FETCH: begin
        if (memAck) begin
          hdr_d = {hdr_q[111:0], memData};
          wc_d  = wc_q + 3'd1;
          if (wc_q == 3'd7) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        flash_dem_d = readFlashEn;
        ram_dem_d   = readRamEn;
        if (readFlashEn)    state_d = S_FLASH;
        else if (readRamEn) state_d = S_RAM;
        else                state_d = S_NEXT;
      end
      S_FLASH: begin
        if (flashAck) state_d = ram_dem_q ? S_RAM : S_NEXT;
      end
      S_RAM: begin
        if (ramAck) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (layer_q == LAST_LAYER) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + 4'd1;
          wc_d    = 3'd0;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; the address is zeroed outside FETCH so it reads 0 in reset.
  always_comb begin
    memReq      = (state_q == S_FETCH);
    memAddr     = memReq ? (HDR_BASE + {19'd0, layer_q, wc_q}) : 26'd0;
    headerOut   = hdr_q;
    headerValid = (state_q == S_EVAL);
    flashReq    = (state_q == S_FLASH);
    ramReq      = (state_q == S_RAM);
    layerIdx    = layer_q;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    dbg_state   = state_q;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8, number of layers walked per pixel (1..16).
REQ-002 SHALL have parameter HDR_BASE, default 26'd0, RAM word address of the layer 0 header.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a pixel's layer walk.
REQ-006 SHALL have port memReq  output  1  header word read request to RAM.
REQ-007 SHALL have port memAddr  output  26  header word address (RAM words).
REQ-008 SHALL have port memAck  input  1  RAM accepted the request; memData is valid in the same cycle.
REQ-009 SHALL have port memData  input  16  header word returned from RAM.
REQ-010 SHALL have port headerOut  output  128  assembled layer header to the ALU.
REQ-011 SHALL have port headerValid  output  1  headerOut complete; ALU outputs are sampled in this cycle.
REQ-012 SHALL have ports readFlashEn, readRamEn  input  1 each  ALU fetch demands for the current layer.
REQ-013 SHALL have ports flashReq, ramReq  output  1 each  grant-pending requests to the flash and RAM data paths.
REQ-014 SHALL have ports flashAck, ramAck  input  1 each  completion of the corresponding request.
REQ-015 SHALL have port layerIdx  output  4  index of the layer being processed.
REQ-016 SHALL have ports busy, done  output  1 each  walk in progress; one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, EVAL, FLASH, RAM, NEXT, DONE.
REQ-018 IDLE: start=1 -> FETCH with layerIdx=0 and word count=0; start SHALL be ignored in every state other than IDLE.
REQ-019 FETCH: memReq SHALL be 1 and memAddr SHALL equal HDR_BASE + layerIdx*8 + wordCount, computed modulo 2^26.
REQ-020 FETCH: memAddr SHALL stay stable until memAck; memReq MAY stay high back-to-back across words.
REQ-021 Each memAck in FETCH SHALL shift the header: headerOut <= {headerOut[111:0], memData}, so word 0 ends in bits [127:112].
REQ-022 Each memAck in FETCH SHALL increment wordCount; the 8th ack SHALL deassert memReq in the next cycle and go to EVAL.
REQ-023 EVAL: headerValid SHALL be 1 for exactly this cycle, and readFlashEn and readRamEn SHALL be registered here.
REQ-024 Transition out of EVAL: flash demand set -> FLASH; else ram demand set -> RAM; else -> NEXT.
REQ-025 FLASH: flashReq SHALL be held at 1 until flashAck; then -> RAM if ram demand was registered, else -> NEXT.
REQ-026 RAM: ramReq SHALL be held at 1 until ramAck, then -> NEXT.
REQ-027 Flash SHALL always be serviced before RAM, and flashReq and ramReq SHALL never both be 1.
REQ-028 NEXT: if layerIdx = NUM_LAYERS-1 -> DONE; else layerIdx+1, wordCount=0, -> FETCH.
REQ-029 DONE: done SHALL be 1 for one cycle, then -> IDLE; layerIdx SHALL hold its last value until the next start.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 Acks arriving while their request is low (memAck outside FETCH, flashAck outside FLASH, ramAck outside RAM) SHALL be ignored.
REQ-032 headerOut SHALL hold its value outside FETCH.
REQ-033 Request-to-ack latency SHALL be unbounded, with no timeout.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, and any walk in progress SHALL be abandoned.
REQ-035 While rst_n=0, all outputs SHALL be 0: memReq, memAddr, headerOut, headerValid, flashReq, ramReq, layerIdx, busy, done.
REQ-036 The first start after rst_n rises SHALL begin at layer 0, word 0.

Verification
REQ-037 NUM_LAYERS=1, start, memAck tied 1, memData=16'h1111..16'h8888, both demands 0 -> headerOut=128'h1111_2222_..._8888, headerValid at cycle 9, done at cycle 11.
REQ-038 HDR_BASE=26'h3FFFFF8, layer 1 fetch -> memAddr=26'h0000000..26'h0000007 (wrap).
REQ-039 In EVAL, readFlashEn=1 and readRamEn=1 -> flashReq held until flashAck (3-cycle delay), then ramReq, with flashReq and ramReq never overlapping.
REQ-040 memAck stalls of 0-5 random cycles per word with NUM_LAYERS=8 -> 64 acks total, layerIdx 0..7, exactly one done pulse.
REQ-041 start pulses while busy=1 -> no effect; spurious flashAck in FETCH -> ignored.
REQ-042 rst_n asserted during the RAM state of layer 3 -> all outputs 0 at once; the next start fetches layer 0 at HDR_BASE.
